// File: rtl/glove_letter_capture.sv
// glove_letter_capture: debounces the glove finger code and issues one draw request
// per held sign. It also owns the text cursor: it advances per glyph, wraps to the
// next line and wraps back to the top of the page.
module glove_letter_capture #(
    parameter int STABLE_CYCLES = 25_000_000,
    parameter int COUNT_W       = 25,
    parameter int GLYPH_W       = 16,
    parameter int GLYPH_H       = 24,
    parameter int SCREEN_W      = 160,
    parameter int SCREEN_H      = 120
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] finger,
    input  logic       draw_busy,
    output logic [4:0] letter,
    output logic [7:0] x_origin,
    output logic [6:0] y_origin,
    output logic       draw_req,
    output logic       page_wrap
);

    localparam logic [COUNT_W-1:0] STABLE = COUNT_W'(STABLE_CYCLES);
    localparam logic [COUNT_W-1:0] ONE    = COUNT_W'(1);
    localparam logic [7:0]         X_LAST = 8'(SCREEN_W - GLYPH_W);
    localparam logic [6:0]         Y_LAST = 7'(SCREEN_H - GLYPH_H);
    localparam logic [7:0]         X_STEP = 8'(GLYPH_W);
    localparam logic [6:0]         Y_STEP = 7'(GLYPH_H);

    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_DRAW, S_ADVANCE} state_t;

    state_t             state, state_next;
    logic [4:0]         sync_a, sync_b;
    logic [4:0]         candidate;
    logic [COUNT_W-1:0] count;
    logic               armed;
    logic               accept;

    // Codes 00000 (space) and the five unassigned patterns are not drawable letters.
    function automatic logic is_letter(input logic [4:0] code);
        case (code)
            5'b00000, 5'b00100, 5'b01010,
            5'b10110, 5'b11010, 5'b11011: is_letter = 1'b0;
            default:                      is_letter = 1'b1;
        endcase
    endfunction

    // Acceptance fires on the edge where the count reaches STABLE_CYCLES, or later if
    // the count has already saturated. That puts the request STABLE_CYCLES+3 edges
    // after the finger change. STABLE_CYCLES must be at least 1.
    assign accept = (state == S_WAIT) && armed && (sync_b == candidate) &&
                    (count >= STABLE - ONE);

    // Two-flop synchroniser. It is cleared on reset so that a held code is
    // re-qualified from scratch.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= finger;
            sync_b <= sync_a;
        end
    end

    // Stability tracking. This keeps running in every state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            candidate <= '0;
            count     <= '0;
            armed     <= 1'b1;
        end else if (sync_b != candidate) begin
            candidate <= sync_b;
            count     <= '0;
            armed     <= 1'b1;
        end else begin
            if (count != STABLE) count <= count + ONE;
            if (accept)          armed <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= S_WAIT;
        else       state <= state_next;
    end

    // Next-state logic and the draw request.
    always_comb begin
        state_next = state;
        draw_req   = 1'b0;
        case (state)
            S_WAIT: begin
                if (accept) begin
                    if (is_letter(candidate))    state_next = S_ISSUE;
                    else if (candidate == 5'd0)  state_next = S_ADVANCE;
                end
            end
            S_ISSUE: begin
                draw_req = 1'b1;
                if (draw_busy) state_next = S_DRAW;
            end
            S_DRAW:    if (!draw_busy) state_next = S_ADVANCE;
            S_ADVANCE: state_next = S_WAIT;
            default:   state_next = S_WAIT;
        endcase
    end

    // Letter latch, cursor stepping and the page-wrap pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            letter    <= '0;
            x_origin  <= '0;
            y_origin  <= '0;
            page_wrap <= 1'b0;
        end else begin
            page_wrap <= 1'b0;
            if (accept && is_letter(candidate)) letter <= candidate;
            if (state == S_ADVANCE) begin
                if (x_origin == X_LAST) begin
                    x_origin <= '0;
                    if (y_origin == Y_LAST) begin
                        y_origin  <= '0;
                        page_wrap <= 1'b1;
                    end else begin
                        y_origin <= y_origin + Y_STEP;
                    end
                end else begin
                    x_origin <= x_origin + X_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_glove_letter_capture.sv
// Directed bench for glove_letter_capture with a short stability window.
module tb_glove_letter_capture;

    logic       CLOCK_50;
    logic       reset;
    logic [4:0] finger;
    logic       draw_busy;
    logic [4:0] letter;
    logic [7:0] x_origin;
    logic [6:0] y_origin;
    logic       draw_req;
    logic       page_wrap;

    int checks = 0;
    int failures = 0;
    int req_cycles = 0;
    int pw_count = 0;

    glove_letter_capture #(.STABLE_CYCLES(8), .COUNT_W(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .finger(finger), .draw_busy(draw_busy),
        .letter(letter), .x_origin(x_origin), .y_origin(y_origin),
        .draw_req(draw_req), .page_wrap(page_wrap)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Running totals of request-high cycles and page-wrap pulses.
    always @(negedge CLOCK_50) begin
        if (draw_req)  req_cycles++;
        if (page_wrap) pw_count++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reset while holding an invalid code, then let that code qualify and be discarded.
    task automatic reset_dut();
        finger = 5'b00100;
        draw_busy = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);
    endtask

    // Present a letter, then answer with busy after dly cycles, held for len cycles.
    task automatic run_draw(input logic [4:0] code, input int dly, input int len,
                            input int ex, input int ey);
        finger = code;
        tick(10);
        chk("req_early", draw_req, 0);
        tick(1);
        chk("req_rise", draw_req, 1);
        chk("letter", letter, code);
        chk("req_x", x_origin, ex);
        chk("req_y", y_origin, ey);
        if (dly > 0) begin
            tick(dly);
            chk("req_hold", draw_req, 1);
        end
        draw_busy = 1'b1;
        tick(1);
        chk("req_drop", draw_req, 0);
        if (len > 1) tick(len - 1);
        draw_busy = 1'b0;
        tick(1);
        chk("x_hold_adv", x_origin, ex);
        tick(1);
    endtask

    int r0, p0, ex, ey;

    initial begin
        finger = 5'b00100;
        draw_busy = 1'b0;
        reset = 1'b1;
        tick(2);
        chk("rst_req", draw_req, 0);
        chk("rst_letter", letter, 0);
        chk("rst_x", x_origin, 0);
        chk("rst_y", y_origin, 0);
        chk("rst_pw", page_wrap, 0);

        // Invalid code held: nothing happens.
        reset = 1'b0;
        r0 = req_cycles;
        tick(40);
        chk("inv_no_req", req_cycles - r0, 0);
        chk("inv_x", x_origin, 0);
        chk("inv_y", y_origin, 0);

        // Letter A with busy raised 2 cycles after the request, held for 5 cycles.
        run_draw(5'b00001, 2, 5, 0, 0);
        chk("a_x_after", x_origin, 16);
        chk("a_y_after", y_origin, 0);
        r0 = req_cycles;
        tick(25);
        chk("a_no_second", req_cycles - r0, 0);

        // Space: the cursor advances once and no request is made.
        reset_dut();
        r0 = req_cycles;
        finger = 5'b00000;
        tick(11);
        chk("sp_x_before", x_origin, 0);
        tick(1);
        chk("sp_x_step", x_origin, 16);
        tick(20);
        chk("sp_x_once", x_origin, 16);
        chk("sp_no_req", req_cycles - r0, 0);

        // A short C glitch is ignored; the held B is drawn.
        reset_dut();
        finger = 5'b00011;
        r0 = req_cycles;
        tick(5);
        chk("c_no_req", req_cycles - r0, 0);
        run_draw(5'b00010, 1, 2, 0, 0);
        chk("b_x_after", x_origin, 16);

        // Fifty draws of alternating A/B: line wrap, then page wrap.
        reset_dut();
        p0 = pw_count;
        for (int i = 0; i < 50; i++) begin
            ex = (i % 10) * 16;
            ey = ((i / 10) % 5) * 24;
            run_draw((i % 2) ? 5'b00010 : 5'b00001, 0, 1, ex, ey);
            if (i == 9) begin
                chk("line_x", x_origin, 0);
                chk("line_y", y_origin, 24);
            end
        end
        chk("page_pw_hi", page_wrap, 1);
        chk("page_x", x_origin, 0);
        chk("page_y", y_origin, 0);
        tick(1);
        chk("page_pw_lo", page_wrap, 0);
        chk("page_pw_once", pw_count - p0, 1);

        // Reset in the middle of a draw.
        reset_dut();
        run_draw(5'b00001, 0, 1, 0, 0);
        finger = 5'b00010;
        tick(11);
        chk("md_req", draw_req, 1);
        draw_busy = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("md_rst_req", draw_req, 0);
        chk("md_rst_x", x_origin, 0);
        chk("md_rst_y", y_origin, 0);
        chk("md_rst_letter", letter, 0);
        reset = 1'b0;
        draw_busy = 1'b0;
        tick(10);
        chk("md_early", draw_req, 0);
        chk("md_no_adv", x_origin, 0);
        tick(1);
        chk("md_rereq", draw_req, 1);
        chk("md_letter", letter, 2);
        draw_busy = 1'b1;
        tick(1);
        draw_busy = 1'b0;
        tick(2);
        chk("md_x_after", x_origin, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
